fft_stage_sequencer: RTL and testbench
======================================

# fft_stage_sequencer

Issue-side controller for the in-place radix-2 FFT butterfly core. On `start` it walks all FFT_N stages, issuing one butterfly per cycle with its butterfly index, even/odd RAM read addresses, twiddle ROM address, stage number and first/last markers. It then counts the core's returned results before advancing to the next stage. It drives the core's `iact`/`ictrl`/`fft_stage`/`input_memory_address` inputs and consumes its `oact`/`octrl` outputs.

## Interface
- FFT_N, 10, log2 of transform length; 2^(FFT_N-1) butterflies per stage.
- STAGE_COUNT_BW, 4, width of stage number; must satisfy 2^STAGE_COUNT_BW > FFT_N.
- DRAIN_TIMEOUT, 64, idle-return cycles before abort (only with FFT_SEQ_TIMEOUT_EN).
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a transform on the loaded RAM; sampled only in IDLE.
- stall  in  1  suppress issue this cycle (RAM port conflict).
- busy  out  1  transform in progress.
- done  out  1  one-cycle pulse when the final stage has drained.
- err  out  1  sticky drain-timeout flag; cleared by the next accepted `start`.
- fft_stage  out  STAGE_COUNT_BW  current stage, 0..FFT_N-1.
- issue_act  out  1  butterfly issued this cycle (core `iact`).
- issue_ctrl  out  2  2'b01 first of stage, 2'b10 last of stage, 2'b00 otherwise.
- bfly_idx  out  FFT_N-1  butterfly index k (core `input_memory_address`).
- rd_addr_even, rd_addr_odd  out  FFT_N  RAM read addresses.
- tw_addr  out  FFT_N-1  twiddle ROM address.
- wb_act  in  1  core result valid (core `oact`).
- wb_ctrl  in  2  core result markers (core `octrl`), informational only.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE. Encoding lives in the package.
- IDLE: on `start` -> ISSUE. Clear k, stage, return counter and err.
- ISSUE: `issue_act = (state==ISSUE) && !stall`. k increments only on `issue_act`. When k = 2^(FFT_N-1)-1 is issued -> DRAIN.
- Address rule for stage s, index k:
  - span = 2^s, pos = k & (span-1), grp = k >> s.
  - even = grp·2·span + pos, odd = even + span.
  - tw = pos << (FFT_N-1-s).
- issue_ctrl = 01 when k==0, 10 when k==max. FFT_N=1 is unsupported.
- Return counter increments on every `wb_act` while in ISSUE or DRAIN. `wb_act` in IDLE/DONE is ignored.
- DRAIN: when count reaches 2^(FFT_N-1), either go to ISSUE with stage+1, k=0, count=0, or, if stage==FFT_N-1, go to DONE.
- A `wb_act` that arrives in the same cycle as the final issue is counted.
- DONE: `done`=1 for one cycle, then IDLE. `fft_stage` holds its last value until the next `start`.
- `start` while busy is ignored. Reset mid-transform returns to IDLE immediately; the core's in-flight results are then ignored.

## Timing
- Reset values: busy=0, done=0, err=0, fft_stage=0, issue_act=0, issue_ctrl=0, bfly_idx=0, rd_addr_even=0, rd_addr_odd=0, tw_addr=0.
- `start` high at edge t: busy=1 and first issue_act from cycle t+1.
- With no stall, a stage issues in 2^(FFT_N-1) consecutive cycles.
- Address/ctrl outputs are registered from k/stage. They are valid whenever issue_act=1 and hold during stall.
- `stall` acts combinationally on issue_act in the same cycle.
- The edge that counts the last result of a stage causes the next stage's first issue the following cycle, or `done` the following cycle.
- `busy` falls the cycle after `done`.

## Configuration
- FFT_SEQ_TIMEOUT_EN defined: in DRAIN, a counter resets on each `wb_act`. After DRAIN_TIMEOUT cycles without one, set err=1 and go to IDLE with no `done`.
- FFT_SEQ_TIMEOUT_EN undefined: err is tied 0 and DRAIN waits indefinitely.

## Structure
- Package fft_seq_pkg holds the state enum and the issue_ctrl encodings (CTRL_FIRST=2'b01, CTRL_LAST=2'b10, CTRL_MID=2'b00).
- Sub-module fft_addr_gen: a combinational (k, stage) -> even/odd/tw address generator, registered in the parent.

## Test plan
- FFT_N=3, start, no stall -> stage 0 pairs (0,1)(2,3)(4,5)(6,7), all tw=0.
- Same run, stage 1 -> pairs (0,2)(1,3)(4,6)(5,7) with tw 0,2,0,2. Stage 2 -> pairs (0,4)(1,5)(2,6)(3,7) with tw 0,1,2,3.
- Check issue_ctrl = 01,00,00,10 for every stage. Model returning wb_act 5 cycles after each issue -> done pulses once; busy lasts 1 + 3·(4+drain) cycles.
- Assert stall on the cycle of k=1 for 3 cycles -> issue_act low for those 3 cycles, bfly_idx holds 1, no index is skipped or repeated.
- Pulse start mid-stage 1 -> ignored. Assert reset during stage 1 -> all outputs return to reset values at once, and the next start begins at stage 0, k=0.
- With FFT_SEQ_TIMEOUT_EN and DRAIN_TIMEOUT=8, withhold the last wb_act of stage 0 -> err=1 after 8 cycles, state IDLE, no done. The next start clears err.

Source files
------------

// File: rtl/fft_seq_pkg.sv
// Shared types and constants for the radix-2 FFT stage sequencer.
package fft_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

  localparam logic [1:0] CTRL_MID   = 2'b00;
  localparam logic [1:0] CTRL_FIRST = 2'b01;
  localparam logic [1:0] CTRL_LAST  = 2'b10;

  function automatic logic [1:0] ctrl_encode(input logic is_first, input logic is_last);
    if (is_first)     return CTRL_FIRST;
    else if (is_last) return CTRL_LAST;
    else              return CTRL_MID;
  endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational butterfly address generator: (k, stage) -> even/odd RAM
// addresses and twiddle ROM address for an in-place radix-2 FFT.
module fft_addr_gen #(
  parameter int FFT_N          = 10,
  parameter int STAGE_COUNT_BW = 4
) (
  input  logic [FFT_N-2:0]          k,
  input  logic [STAGE_COUNT_BW-1:0] stage,
  output logic [FFT_N-1:0]          addr_even,
  output logic [FFT_N-1:0]          addr_odd,
  output logic [FFT_N-2:0]          tw
);

  logic [FFT_N-1:0] k_ext;
  logic [FFT_N-1:0] span;
  logic [FFT_N-1:0] pos;
  logic [FFT_N-1:0] grp;

  always_comb begin
    k_ext     = {1'b0, k};
    span      = {{(FFT_N-1){1'b0}}, 1'b1} << stage;
    pos       = k_ext & (span - 1'b1);
    grp       = k_ext >> stage;
    // Each group of span butterflies occupies 2*span words; odd partner sits span above.
    addr_even = ((grp << stage) << 1) | pos;
    addr_odd  = addr_even + span;
    tw        = (FFT_N-1)'(pos << (STAGE_COUNT_BW'(FFT_N-1) - stage));
  end

endmodule

// File: rtl/fft_stage_sequencer.sv
// Issue-side sequencer for the in-place radix-2 FFT butterfly core.
// Optional drain watchdog enabled by defining FFT_SEQ_TIMEOUT_EN.
module fft_stage_sequencer
  import fft_seq_pkg::*;
#(
  parameter int FFT_N          = 10,
  parameter int STAGE_COUNT_BW = 4,
  parameter int DRAIN_TIMEOUT  = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      stall,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [STAGE_COUNT_BW-1:0] fft_stage,
  output logic                      issue_act,
  output logic [1:0]                issue_ctrl,
  output logic [FFT_N-2:0]          bfly_idx,
  output logic [FFT_N-1:0]          rd_addr_even,
  output logic [FFT_N-1:0]          rd_addr_odd,
  output logic [FFT_N-2:0]          tw_addr,
  input  logic                      wb_act,
  input  logic [1:0]                wb_ctrl
);

  localparam logic [FFT_N-2:0]          K_LAST     = '1;
  localparam logic [FFT_N-1:0]          CNT_FULL   = {1'b1, {(FFT_N-1){1'b0}}};
  localparam logic [STAGE_COUNT_BW-1:0] STAGE_LAST = STAGE_COUNT_BW'(FFT_N-1);

  seq_state_t                state_q, state_d;
  logic [FFT_N-2:0]          k_q, k_d;
  logic [STAGE_COUNT_BW-1:0] stage_q, stage_d;
  logic [FFT_N-1:0]          cnt_q, cnt_d, cnt_inc;
  logic                      wb_counted;
  logic                      drain_timeout;
  logic [FFT_N-1:0]          even_nxt, odd_nxt;
  logic [FFT_N-2:0]          tw_nxt;
  logic                      unused_wb_ctrl;

  assign unused_wb_ctrl = ^wb_ctrl;
  assign wb_counted     = wb_act && (state_q == ST_ISSUE || state_q == ST_DRAIN);
  assign cnt_inc        = cnt_q + {{(FFT_N-1){1'b0}}, wb_counted};
  assign issue_act      = (state_q == ST_ISSUE) && !stall;
  assign busy           = (state_q != ST_IDLE);
  assign done           = (state_q == ST_DONE);
  assign fft_stage      = stage_q;

`ifdef FFT_SEQ_TIMEOUT_EN
  localparam int              TO_W    = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(DRAIN_TIMEOUT - 1);

  logic [TO_W-1:0] quiet_q;
  logic            err_q;

  // Cycles spent in DRAIN since the last returned result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                quiet_q <= '0;
    else if (state_q != ST_DRAIN || wb_act)    quiet_q <= '0;
    else                                       quiet_q <= quiet_q + 1'b1;
  end

  assign drain_timeout = (state_q == ST_DRAIN) && !wb_act && (quiet_q == TO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                             err_q <= 1'b0;
    else if (state_q == ST_IDLE && start)   err_q <= 1'b0;
    else if (drain_timeout)                 err_q <= 1'b1;
  end

  assign err = err_q;
`else
  localparam int unused_drain_timeout = DRAIN_TIMEOUT;
  assign drain_timeout = 1'b0;
  assign err           = 1'b0;
`endif

  // NOTE: every always_comb target gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    stage_d = stage_q;
    cnt_d   = cnt_inc;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = ST_ISSUE;
          k_d     = '0;
          stage_d = '0;
        end
      end
      ST_ISSUE: begin
        if (issue_act) begin
          if (k_q == K_LAST) state_d = ST_DRAIN;
          else               k_d     = k_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (cnt_inc == CNT_FULL) begin
          cnt_d = '0;
          k_d   = '0;
          if (stage_q == STAGE_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ISSUE;
            stage_d = stage_q + 1'b1;
          end
        end else if (drain_timeout) begin
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      stage_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  fft_addr_gen #(
    .FFT_N          (FFT_N),
    .STAGE_COUNT_BW (STAGE_COUNT_BW)
  ) u_addr_gen (
    .k         (k_d),
    .stage     (stage_d),
    .addr_even (even_nxt),
    .addr_odd  (odd_nxt),
    .tw        (tw_nxt)
  );

  // Issue fields are computed from the next pointer so they line up with issue_act.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bfly_idx     <= '0;
      rd_addr_even <= '0;
      rd_addr_odd  <= '0;
      tw_addr      <= '0;
      issue_ctrl   <= CTRL_MID;
    end else if (state_d == ST_ISSUE) begin
      bfly_idx     <= k_d;
      rd_addr_even <= even_nxt;
      rd_addr_odd  <= odd_nxt;
      tw_addr      <= tw_nxt;
      issue_ctrl   <= ctrl_encode(k_d == '0, k_d == K_LAST);
    end else begin
      issue_ctrl   <= CTRL_MID;
    end
  end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Self-checking bench for fft_stage_sequencer (FFT_N=3) with a latency-modelled
// butterfly core and a reference schedule computed from the FFT addressing rules.
module tb_fft_stage_sequencer;

  localparam int N    = 3;
  localparam int SBW  = 4;
  localparam int TO   = 8;
  localparam int HALF = 1 << (N - 1);

  logic           clk = 1'b0;
  logic           reset, start, stall, wb_act;
  logic [1:0]     wb_ctrl;
  logic           busy, done, err, issue_act;
  logic [SBW-1:0] fft_stage;
  logic [1:0]     issue_ctrl;
  logic [N-2:0]   bfly_idx, tw_addr;
  logic [N-1:0]   rd_addr_even, rd_addr_odd;

  always #5 clk = ~clk;

  fft_stage_sequencer #(.FFT_N(N), .STAGE_COUNT_BW(SBW), .DRAIN_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .busy(busy), .done(done), .err(err), .fft_stage(fft_stage),
    .issue_act(issue_act), .issue_ctrl(issue_ctrl), .bfly_idx(bfly_idx),
    .rd_addr_even(rd_addr_even), .rd_addr_odd(rd_addr_odd), .tw_addr(tw_addr),
    .wb_act(wb_act), .wb_ctrl(wb_ctrl)
  );

  typedef struct {int stage; int k; int even; int odd; int tw; int ctrl;} rec_t;

  int          checks = 0;
  int          errors = 0;
  rec_t        obs_q[$];
  logic [15:0] ret_sr;
  int          lat;
  bit          withhold;
  int          done_cnt, busy_cnt, cyc;
  bit          s_busy, s_done, s_err, s_issue, wb_cur;
  int          s_idx, s_stage;
  int          hist_issue[512];
  int          hist_idx[512];
  string       first_bad;

  // One clock cycle: sample at the falling edge, run the core model, return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    s_busy = busy; s_done = done; s_err = err; s_issue = issue_act;
    s_idx = int'(bfly_idx); s_stage = int'(fft_stage);
    if (issue_act)
      obs_q.push_back('{int'(fft_stage), int'(bfly_idx), int'(rd_addr_even),
                        int'(rd_addr_odd), int'(tw_addr), int'(issue_ctrl)});
    done_cnt += int'(done);
    busy_cnt += int'(busy);
    if (cyc < 512) begin hist_issue[cyc] = int'(issue_act); hist_idx[cyc] = int'(bfly_idx); end
    ret_sr  = {ret_sr[14:0], issue_act && !(withhold && fft_stage == 0 && int'(bfly_idx) == HALF - 1)};
    wb_act  = ret_sr[lat];
    wb_cur  = wb_act;
    wb_ctrl = 2'($urandom);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    ret_sr = '0; wb_act = 1'b0; obs_q.delete();
    done_cnt = 0; busy_cnt = 0; cyc = 0;
  endtask

  task automatic do_reset();
    start = 1'b0; stall = 1'b0; reset = 1'b0;
    ret_sr = '0; wb_act = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  // Reference schedule: count of observed issues in stage s that disagree with the FFT rules.
  function automatic int sched_bad(int s);
    int span = 1 << s;
    int idx  = 0;
    int bad  = 0;
    foreach (obs_q[i]) begin
      if (obs_q[i].stage == s) begin
        int ee = (idx / span) * 2 * span + idx % span;
        int et = (idx % span) * (HALF / span);
        int ec = (idx == 0) ? 1 : ((idx == HALF - 1) ? 2 : 0);
        if (obs_q[i].k != idx || obs_q[i].even != ee || obs_q[i].odd != ee + span ||
            obs_q[i].tw != et || obs_q[i].ctrl != ec) begin
          if (bad == 0)
            first_bad = $sformatf("k=%0d got e=%0d o=%0d tw=%0d c=%0d want e=%0d o=%0d tw=%0d c=%0d",
                                  idx, obs_q[i].even, obs_q[i].odd, obs_q[i].tw, obs_q[i].ctrl,
                                  ee, ee + span, et, ec);
          bad++;
        end
        idx++;
      end
    end
    if (idx != HALF) begin
      if (bad == 0) first_bad = $sformatf("issue count %0d want %0d", idx, HALF);
      bad++;
    end
    return bad;
  endfunction

  task automatic run_transform(input int stall_pct, input bit k1_stall, input bit start_mid,
                               output bit timed_out);
    bit mid_sent = 1'b0;
    clear_model();
    timed_out = 1'b1;
    stall = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 500; i++) begin
      stall = (stall_pct > 0 && $urandom_range(99) < stall_pct) || (k1_stall && cyc >= 2 && cyc <= 4);
      start = start_mid && !mid_sent && s_stage == 1 && s_busy;
      if (start) mid_sent = 1'b1;
      tick();
      if (s_done) begin timed_out = 1'b0; break; end
    end
    start = 1'b0; stall = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    start = 1'b0; stall = 1'b0; wb_act = 1'b0; wb_ctrl = 2'b00; reset = 1'b0;
    ret_sr = '0; lat = 5; withhold = 1'b0; cyc = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0)          begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (err !== 1'b0)           begin errors++; $display("FAIL reset_err got=%b want=0", err); end
    checks++; if (fft_stage !== '0)       begin errors++; $display("FAIL reset_stage got=%0d want=0", fft_stage); end
    checks++; if (issue_act !== 1'b0)     begin errors++; $display("FAIL reset_issue_act got=%b want=0", issue_act); end
    checks++; if (issue_ctrl !== 2'b00)   begin errors++; $display("FAIL reset_ctrl got=%b want=00", issue_ctrl); end
    checks++; if (bfly_idx !== '0)        begin errors++; $display("FAIL reset_idx got=%0d want=0", bfly_idx); end
    checks++; if (rd_addr_even !== '0)    begin errors++; $display("FAIL reset_even got=%0d want=0", rd_addr_even); end
    checks++; if (rd_addr_odd !== '0)     begin errors++; $display("FAIL reset_odd got=%0d want=0", rd_addr_odd); end
    checks++; if (tw_addr !== '0)         begin errors++; $display("FAIL reset_tw got=%0d want=0", tw_addr); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_no_stall();
    bit to;
    int want_busy;
    lat = 5;
    run_transform(0, 1'b0, 1'b0, to);
    want_busy = 1 + N * (HALF + lat);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL nostall_done_seen got_timeout=%b want=0", to); end
    for (int s = 0; s < N; s++) begin
      int b = sched_bad(s);
      checks++; if (b !== 0) begin errors++; $display("FAIL nostall_stage%0d bad=%0d want=0 (%s)", s, b, first_bad); end
    end
    checks++; if (done_cnt !== 1)         begin errors++; $display("FAIL nostall_done_pulses got=%0d want=1", done_cnt); end
    checks++; if (busy_cnt !== want_busy) begin errors++; $display("FAIL nostall_busy_cycles got=%0d want=%0d", busy_cnt, want_busy); end
    checks++; if (s_busy !== 1'b0)        begin errors++; $display("FAIL nostall_busy_after_done got=%b want=0", s_busy); end
    checks++; if (s_err !== 1'b0)         begin errors++; $display("FAIL nostall_err got=%b want=0", s_err); end
    tick(); tick();
    checks++; if (s_stage !== N - 1)      begin errors++; $display("FAIL nostall_stage_hold got=%0d want=%0d", s_stage, N - 1); end
  endtask

  task automatic test_random_stall();
    bit to;
    for (int r = 0; r < 6; r++) begin
      lat = int'($urandom_range(1, 6));
      run_transform(30, 1'b0, 1'b0, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL rnd%0d_done_seen got_timeout=%b want=0", r, to); end
      for (int s = 0; s < N; s++) begin
        int b = sched_bad(s);
        checks++; if (b !== 0) begin errors++; $display("FAIL rnd%0d_stage%0d bad=%0d want=0 (%s)", r, s, b, first_bad); end
      end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL rnd%0d_done_pulses got=%0d want=1", r, done_cnt); end
      checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL rnd%0d_err got=%b want=0", r, s_err); end
    end
  endtask

  task automatic test_stall_k1();
    bit to;
    lat = 3;
    run_transform(0, 1'b1, 1'b0, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL k1stall_done_seen got_timeout=%b want=0", to); end
    for (int c = 2; c <= 4; c++) begin
      checks++; if (hist_issue[c] !== 0) begin errors++; $display("FAIL k1stall_issue_c%0d got=%0d want=0", c, hist_issue[c]); end
      checks++; if (hist_idx[c] !== 1)   begin errors++; $display("FAIL k1stall_idx_c%0d got=%0d want=1", c, hist_idx[c]); end
    end
    checks++; if (hist_issue[5] !== 1 || hist_idx[5] !== 1)
      begin errors++; $display("FAIL k1stall_resume got issue=%0d idx=%0d want issue=1 idx=1", hist_issue[5], hist_idx[5]); end
    for (int s = 0; s < N; s++) begin
      int b = sched_bad(s);
      checks++; if (b !== 0) begin errors++; $display("FAIL k1stall_stage%0d bad=%0d want=0 (%s)", s, b, first_bad); end
    end
  endtask

  task automatic test_start_ignored();
    bit to;
    lat = 4;
    run_transform(0, 1'b0, 1'b1, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL midstart_done_seen got_timeout=%b want=0", to); end
    for (int s = 0; s < N; s++) begin
      int b = sched_bad(s);
      checks++; if (b !== 0) begin errors++; $display("FAIL midstart_stage%0d bad=%0d want=0 (%s)", s, b, first_bad); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL midstart_done_pulses got=%0d want=1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    bit to;
    bit hit = 1'b0;
    lat = 5;
    clear_model();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      tick();
      hit = s_stage == 1 && s_issue && s_idx == 1;
    end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL rstmid_reach_stage1 got=%b want=1", hit); end
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    checks++; if (issue_act !== 1'b0) begin errors++; $display("FAIL rstmid_issue_act got=%b want=0", issue_act); end
    checks++; if (fft_stage !== '0)   begin errors++; $display("FAIL rstmid_stage got=%0d want=0", fft_stage); end
    checks++; if (issue_ctrl !== 2'b00 || bfly_idx !== '0 || rd_addr_even !== '0 || rd_addr_odd !== '0 || tw_addr !== '0)
      begin errors++; $display("FAIL rstmid_fields got ctrl=%b idx=%0d e=%0d o=%0d tw=%0d want all 0",
                               issue_ctrl, bfly_idx, rd_addr_even, rd_addr_odd, tw_addr); end
    ret_sr = '0; wb_act = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    run_transform(0, 1'b0, 1'b0, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL rstmid_rerun_done got_timeout=%b want=0", to); end
    checks++; if (obs_q.size() == 0 || obs_q[0].stage !== 0 || obs_q[0].k !== 0)
      begin errors++; $display("FAIL rstmid_first_issue size=%0d want first stage=0 k=0", obs_q.size()); end
    for (int s = 0; s < N; s++) begin
      int b = sched_bad(s);
      checks++; if (b !== 0) begin errors++; $display("FAIL rstmid_stage%0d bad=%0d want=0 (%s)", s, b, first_bad); end
    end
  endtask

  task automatic test_drain_timeout();
    int last_wb = -1;
    lat = 5;
    withhold = 1'b1;
    clear_model();
    start = 1'b1;
    tick();
    start = 1'b0;
`ifdef FFT_SEQ_TIMEOUT_EN
    begin
      int err_cyc = -1;
      bit err_busy = 1'b1;
      for (int i = 0; i < 200; i++) begin
        tick();
        if (wb_cur) last_wb = cyc - 1;
        if (s_err) begin err_cyc = cyc - 1; err_busy = s_busy; break; end
      end
      checks++; if (err_cyc < 0) begin errors++; $display("FAIL timeout_err_raised got=0 want=1"); end
      checks++; if (err_cyc - last_wb !== TO + 1)
        begin errors++; $display("FAIL timeout_latency got=%0d want=%0d", err_cyc - last_wb, TO + 1); end
      checks++; if (err_busy !== 1'b0) begin errors++; $display("FAIL timeout_idle got_busy=%b want=0", err_busy); end
      checks++; if (done_cnt !== 0)    begin errors++; $display("FAIL timeout_no_done got=%0d want=0", done_cnt); end
      withhold = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL timeout_err_clear got=%b want=0", s_err); end
    end
`else
    begin
      bit any_err = 1'b0;
      for (int i = 0; i < 100; i++) begin
        tick();
        if (wb_cur) last_wb = cyc - 1;
        any_err |= s_err;
      end
      checks++; if (any_err !== 1'b0) begin errors++; $display("FAIL nodog_err got=%b want=0", any_err); end
      checks++; if (s_busy !== 1'b1)  begin errors++; $display("FAIL nodog_still_busy got=%b want=1", s_busy); end
      checks++; if (done_cnt !== 0)   begin errors++; $display("FAIL nodog_no_done got=%0d want=0", done_cnt); end
      checks++; if (last_wb !== 8)    begin errors++; $display("FAIL nodog_last_return got=%0d want=8", last_wb); end
    end
`endif
    withhold = 1'b0;
    do_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_no_stall();
    test_stall_k1();
    test_random_stall();
    test_start_ignored();
    test_reset_mid();
    test_drain_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
